// File: rtl/flex_sr_pkg.sv
// Shared helpers for the flexible shift-register family: counter width and fill word.
package flex_sr_pkg;

   // Widest word the fill helper can describe; callers slice the low NUM_BITS.
   localparam int unsigned MaxWidth = 256;

   // Ceiling log2, never less than 1 so a counter always has at least one bit.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      while ((64'd1 << result) < 64'(value)) begin
         result++;
      end
      if (result == 0) begin
         result = 1;
      end
      return result;
   endfunction

   // Reset/clear word: all ones in the low num_bits when reset_ones, else all zeros.
   function automatic logic [MaxWidth-1:0] fill_value(input int unsigned num_bits,
                                                      input bit reset_ones);
      logic [MaxWidth-1:0] mask;
      mask = '0;
      for (int unsigned i = 0; i < MaxWidth; i++) begin
         if (i < num_bits) begin
            mask[i] = 1'b1;
         end
      end
      return reset_ones ? mask : '0;
   endfunction

endpackage

// File: rtl/flex_stp_framer_if.sv
// Word hand-off bus between the framer holding register and its consumer.
interface flex_stp_framer_if #(
   parameter int unsigned NUM_BITS = 8
) ();

   logic [NUM_BITS-1:0] parallel_out;
   logic                out_valid;
   logic                out_ready;

   // Framer side: offers words.
   modport master (
      output parallel_out,
      output out_valid,
      input  out_ready
   );

   // Consumer side: accepts words.
   modport slave (
      input  parallel_out,
      input  out_valid,
      output out_ready
   );

endinterface

// File: rtl/flex_stp_bit_counter.sv
// Bit position counter for one word; wrap flags the edge that completes a word.
module flex_stp_bit_counter
   import flex_sr_pkg::*;
#(
   parameter  int unsigned NUM_BITS = 8,
   localparam int unsigned CNT_W    = clog2(NUM_BITS)
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             clear,
   input  logic             count_enable,
   output logic [CNT_W-1:0] count,
   output logic             wrap
);

   localparam logic [CNT_W-1:0] Last = CNT_W'(NUM_BITS - 1);

   logic [CNT_W-1:0] count_q;

   // Wrap is combinational so the top can capture the word on the same edge.
   assign wrap  = count_enable && (count_q == Last);
   assign count = count_q;

   // Count enabled bits, returning to zero after the last bit of a word.
   always_ff @(posedge clk) begin
      if (!n_rst || clear) begin
         count_q <= '0;
      end else if (count_enable) begin
         count_q <= wrap ? '0 : count_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/flex_stp_framer.sv
// Serial-to-parallel framer: run-time shift direction per word, holding register
// with valid/ready hand-off and sticky overrun when a finished word cannot be stored.
module flex_stp_framer
   import flex_sr_pkg::*;
#(
   parameter  int unsigned NUM_BITS   = 8,
   parameter  int unsigned RESET_ONES = 1,
   localparam int unsigned CNT_W      = clog2(NUM_BITS)
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                clear,
   input  logic                shift_enable,
   input  logic                serial_in,
   input  logic                msb_first,
   output logic [NUM_BITS-1:0] shift_data,
   output logic [CNT_W-1:0]    bit_count,
   output logic                overrun,
   flex_stp_framer_if.master   out_bus
);

   localparam logic [MaxWidth-1:0] FillWide = fill_value(NUM_BITS, RESET_ONES != 0);
   localparam logic [NUM_BITS-1:0] Fill     = FillWide[NUM_BITS-1:0];

   logic [NUM_BITS-1:0] shift_q;
   logic [NUM_BITS-1:0] shift_next;
   logic [NUM_BITS-1:0] hold_q;
   logic                valid_q;
   logic                overrun_q;
   logic                dir_q;
   logic                dir_now;
   logic                word_done;
   logic                accept;

   flex_stp_bit_counter #(
      .NUM_BITS (NUM_BITS)
   ) u_bit_counter (
      .clk          (clk),
      .n_rst        (n_rst),
      .clear        (clear),
      .count_enable (shift_enable),
      .count        (bit_count),
      .wrap         (word_done)
   );

   // First bit of a word follows the pin directly; later bits use the latched direction.
   always_comb begin
      dir_now    = (bit_count == '0) ? msb_first : dir_q;
      shift_next = dir_now ? {shift_q[NUM_BITS-2:0], serial_in}
                           : {serial_in, shift_q[NUM_BITS-1:1]};
      accept     = valid_q && out_bus.out_ready;
   end

   // Shift register, direction latch and holding register with hand-off state.
   always_ff @(posedge clk) begin
      if (!n_rst || clear) begin
         shift_q   <= Fill;
         hold_q    <= Fill;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         dir_q     <= 1'b1;
      end else begin
         if (bit_count == '0) begin
            dir_q <= msb_first;
         end
         if (shift_enable) begin
            shift_q <= shift_next;
         end
         if (word_done) begin
            // A pending word is only replaced when it is accepted on this very edge.
            if (!valid_q || out_bus.out_ready) begin
               hold_q  <= shift_next;
               valid_q <= 1'b1;
            end else begin
               overrun_q <= 1'b1;
            end
         end else if (accept) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign shift_data           = shift_q;
   assign overrun              = overrun_q;
   assign out_bus.parallel_out = hold_q;
   assign out_bus.out_valid    = valid_q;

endmodule

// File: tb/tb_flex_stp_framer.sv
// Self-checking bench for flex_stp_framer: directed scenarios plus randomized traffic
// compared against a word-level reference model.
module tb_flex_stp_framer;
   import flex_sr_pkg::*;

   localparam int unsigned N     = 8;
   localparam int unsigned CNT_W = clog2(N);
   localparam logic [N-1:0] FILL = 8'hFF;

   logic           clk = 1'b0;
   logic           n_rst = 1'b0;
   logic           clear = 1'b0;
   logic           shift_enable = 1'b0;
   logic           serial_in = 1'b0;
   logic           msb_first = 1'b1;
   logic [N-1:0]   shift_data;
   logic [CNT_W-1:0] bit_count;
   logic           overrun;

   flex_stp_framer_if #(.NUM_BITS(N)) bus ();

   flex_stp_framer #(
      .NUM_BITS   (N),
      .RESET_ONES (1)
   ) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .clear        (clear),
      .shift_enable (shift_enable),
      .serial_in    (serial_in),
      .msb_first    (msb_first),
      .shift_data   (shift_data),
      .bit_count    (bit_count),
      .overrun      (overrun),
      .out_bus      (bus)
   );

   always #5 clk = ~clk;

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model: words assembled from the list of received bits.
   int           m_cnt;
   logic         m_bits [N];
   logic         m_dir;
   logic [N-1:0] m_par;
   logic         m_valid;
   logic         m_ovr;
   logic [N-1:0] m_sd;
   logic         m_sd_known;

   function automatic logic [N-1:0] assemble();
      logic [N-1:0] w;
      w = '0;
      for (int i = 0; i < N; i++) begin
         if (m_dir) w[N-1-i] = m_bits[i];
         else       w[i]     = m_bits[i];
      end
      return w;
   endfunction

   // Apply one cycle of inputs, advance the clock, update the model.
   task automatic tick(input logic rst, input logic clr, input logic se, input logic sin,
                       input logic msb, input logic rdy);
      logic         done;
      logic [N-1:0] word;
      logic         acc;
      n_rst = rst; clear = clr; shift_enable = se; serial_in = sin; msb_first = msb;
      bus.out_ready = rdy;
      @(posedge clk);
      if (!rst || clr) begin
         m_cnt = 0; m_par = FILL; m_valid = 1'b0; m_ovr = 1'b0;
         m_sd = FILL; m_sd_known = 1'b1;
      end else begin
         acc  = m_valid && rdy;
         done = 1'b0;
         word = '0;
         if (se) begin
            if (m_cnt == 0) m_dir = msb;
            m_bits[m_cnt] = sin;
            if (m_cnt == N - 1) begin
               done = 1'b1;
               word = assemble();
            end
            m_cnt      = (m_cnt + 1) % N;
            m_sd_known = done;
            m_sd       = word;
         end
         if (done) begin
            if (!m_valid || rdy) begin
               m_par   = word;
               m_valid = 1'b1;
            end else begin
               m_ovr = 1'b1;
            end
         end else if (acc) begin
            m_valid = 1'b0;
         end
      end
      #1;
   endtask

   // Shift a whole word in arrival order, optional idle gaps, ready on the last bit only.
   task automatic send_word(input logic [N-1:0] value, input logic msb, input logic last_rdy,
                            input bit gaps);
      logic b;
      for (int i = 0; i < N; i++) begin
         b = msb ? value[N-1-i] : value[i];
         if (gaps) begin
            repeat ($urandom_range(2)) tick(1, 0, 0, 0, msb, 0);
         end
         tick(1, 0, 1, b, msb, (i == N - 1) ? last_rdy : 1'b0);
      end
   endtask

   task automatic test_reset();
      tick(0, 0, 0, 0, 1, 0);
      tests_run++;
      if (shift_data !== 8'hFF) begin
         tests_failed++; $display("FAIL reset_shift_data got=%h exp=ff", shift_data);
      end
      tests_run++;
      if (bus.parallel_out !== 8'hFF) begin
         tests_failed++; $display("FAIL reset_parallel_out got=%h exp=ff", bus.parallel_out);
      end
      tests_run++;
      if (bit_count !== 0 || bus.out_valid !== 1'b0 || overrun !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_flags got cnt=%0d v=%b o=%b exp 0/0/0", bit_count,
                  bus.out_valid, overrun);
      end
   endtask

   task automatic test_msb_first();
      logic [N-1:0] pattern;
      pattern = 8'hA5;
      for (int i = 0; i < N; i++) begin
         repeat ($urandom_range(1, 3)) tick(1, 0, 0, 0, 1, 0);
         tests_run++;
         if (bit_count !== CNT_W'(i) || bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL msb_gap_hold bit=%0d got cnt=%0d v=%b exp cnt=%0d v=0", i,
                     bit_count, bus.out_valid, i);
         end
         tick(1, 0, 1, pattern[N-1-i], 1, 0);
      end
      tests_run++;
      if (bus.parallel_out !== 8'hA5 || bus.out_valid !== 1'b1 || bit_count !== 0) begin
         tests_failed++;
         $display("FAIL msb_word got po=%h v=%b cnt=%0d exp po=a5 v=1 cnt=0",
                  bus.parallel_out, bus.out_valid, bit_count);
      end
      tests_run++;
      if (shift_data !== 8'hA5) begin
         tests_failed++; $display("FAIL msb_shift_data got=%h exp=a5", shift_data);
      end
   endtask

   task automatic test_lsb_first();
      logic [N-1:0] bits;
      tick(1, 0, 0, 0, 0, 1);  // accept the pending word
      bits = 8'b0001_1110;     // arrival order 0,1,1,1,1,0,0,0 as bit[i]
      for (int i = 0; i < N; i++) begin
         tick(1, 0, 1, bits[i], (i >= 3) ? 1'b1 : 1'b0, 0);
      end
      tests_run++;
      if (bus.parallel_out !== 8'h1E || bus.out_valid !== 1'b1 || overrun !== 1'b0) begin
         tests_failed++;
         $display("FAIL lsb_word got po=%h v=%b o=%b exp po=1e v=1 o=0", bus.parallel_out,
                  bus.out_valid, overrun);
      end
   endtask

   task automatic test_overrun();
      tick(1, 0, 0, 0, 1, 1);
      send_word(8'h11, 1, 0, 0);
      send_word(8'h22, 1, 0, 0);
      tests_run++;
      if (bus.parallel_out !== 8'h11 || bus.out_valid !== 1'b1 || overrun !== 1'b1) begin
         tests_failed++;
         $display("FAIL overrun_drop got po=%h v=%b o=%b exp po=11 v=1 o=1",
                  bus.parallel_out, bus.out_valid, overrun);
      end
      tick(1, 0, 0, 0, 1, 1);
      tests_run++;
      if (bus.out_valid !== 1'b0 || overrun !== 1'b1) begin
         tests_failed++;
         $display("FAIL overrun_sticky got v=%b o=%b exp v=0 o=1", bus.out_valid, overrun);
      end
      tick(1, 1, 0, 0, 1, 0);
      tests_run++;
      if (overrun !== 1'b0 || bus.parallel_out !== 8'hFF) begin
         tests_failed++;
         $display("FAIL overrun_clear got o=%b po=%h exp o=0 po=ff", overrun, bus.parallel_out);
      end
   endtask

   task automatic test_back_to_back();
      send_word(8'h11, 1, 0, 0);
      send_word(8'h33, 1, 1, 0);
      tests_run++;
      if (bus.parallel_out !== 8'h33 || bus.out_valid !== 1'b1 || overrun !== 1'b0) begin
         tests_failed++;
         $display("FAIL accept_and_complete got po=%h v=%b o=%b exp po=33 v=1 o=0",
                  bus.parallel_out, bus.out_valid, overrun);
      end
   endtask

   task automatic test_clear_mid_word();
      tick(1, 0, 0, 0, 1, 1);
      tick(1, 0, 1, 0, 1, 0);
      tick(1, 0, 1, 1, 1, 0);
      tick(1, 0, 1, 0, 1, 0);
      tick(1, 1, 1, 1, 1, 0);
      tests_run++;
      if (bit_count !== 0 || shift_data !== 8'hFF || bus.out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL clear_mid_word got cnt=%0d sd=%h v=%b exp cnt=0 sd=ff v=0",
                  bit_count, shift_data, bus.out_valid);
      end
      send_word(8'h5A, 1, 0, 1);
      tests_run++;
      if (bus.parallel_out !== 8'h5A || bus.out_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL clear_next_word got po=%h v=%b exp po=5a v=1", bus.parallel_out,
                  bus.out_valid);
      end
   endtask

   task automatic test_random();
      logic se, sin, msb, rdy, clr;
      for (int c = 0; c < 600; c++) begin
         se  = ($urandom_range(3) != 0);
         sin = 1'($urandom);
         msb = 1'($urandom);
         rdy = ($urandom_range(3) == 0);
         clr = ($urandom_range(99) == 0);
         tick(1, clr, se, sin, msb, rdy);
         tests_run++;
         if (bit_count !== CNT_W'(m_cnt) || bus.out_valid !== m_valid || overrun !== m_ovr)
         begin
            tests_failed++;
            $display("FAIL rand_state c=%0d got cnt=%0d v=%b o=%b exp cnt=%0d v=%b o=%b", c,
                     bit_count, bus.out_valid, overrun, m_cnt, m_valid, m_ovr);
         end
         tests_run++;
         if (bus.parallel_out !== m_par) begin
            tests_failed++;
            $display("FAIL rand_parallel_out c=%0d got=%h exp=%h", c, bus.parallel_out, m_par);
         end
         if (m_sd_known) begin
            tests_run++;
            if (shift_data !== m_sd) begin
               tests_failed++;
               $display("FAIL rand_shift_data c=%0d got=%h exp=%h", c, shift_data, m_sd);
            end
         end
      end
   endtask

   initial begin
      bus.out_ready = 1'b0;
      m_cnt = 0; m_dir = 1'b1; m_par = FILL; m_valid = 1'b0; m_ovr = 1'b0;
      m_sd = FILL; m_sd_known = 1'b1;
      for (int i = 0; i < N; i++) m_bits[i] = 1'b0;
      test_reset();
      test_msb_first();
      test_lsb_first();
      test_overrun();
      test_back_to_back();
      test_clear_mid_word();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
